// File: rtl/mod_sigma1_if.sv
// Stream bundle for the Sigma1 transform: one input word per cycle and a registered result.
`default_nettype none

interface mod_sigma1_if;
  logic        in_valid;
  logic [0:31] A;
  logic [0:31] Y;
  logic        out_valid;

  modport master (
    output in_valid,
    output A,
    input  Y,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  A,
    output Y,
    output out_valid
  );
endinterface

`default_nettype wire

// File: rtl/mod_sigma1.sv
// ---------------------------------------------------------------------------
// mod_sigma1 : SHA-256 Sigma1 (ROTR6 ^ ROTR11 ^ ROTR25), one-cycle registered
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_sigma1 (
  input  wire           clk,
  input  wire           rst_n,
  mod_sigma1_if.slave   bus
);

  logic [0:31] sigma;
  logic [0:31] y_q;
  logic        valid_q;

  // Index 0 is the MSB, so a right rotation by n moves the low n bits (n-element tail) to the front.
  always_comb begin
    sigma = {bus.A[26:31], bus.A[0:25]}
          ^ {bus.A[21:31], bus.A[0:20]}
          ^ {bus.A[7:31],  bus.A[0:6]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q <= sigma;
      end
    end
  end

  assign bus.Y         = y_q;
  assign bus.out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_sigma1.sv
// Self-checking bench for mod_sigma1: directed table, idle/hold, async reset, random sweep.
`default_nettype none

module tb_mod_sigma1;

  logic clk;
  logic rst_n;

  mod_sigma1_if bus ();

  mod_sigma1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] y;
  } vec_t;

  vec_t        table_v[6];
  logic [31:0] exp_q[$];
  logic [31:0] held;
  int          checks;
  int          errors;

  function automatic logic [31:0] sigma1_ref(input logic [31:0] a);
    return ((a >> 6)  | (a << 26))
         ^ ((a >> 11) | (a << 21))
         ^ ((a >> 25) | (a << 7));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle from the falling edge and checks the result just after the next rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] exp_y, input string name);
    logic [31:0] e;
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = a;
    if (v) exp_q.push_back(exp_y);
    #1;
    check({name, "_hold_between_edges"}, bus.Y, held);
    @(posedge clk);
    #1;
    if (v) begin
      check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
        check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({name, "_Y"}, bus.Y, e);
        held = e;
      end
    end else begin
      check({name, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({name, "_idle_Y_held"}, bus.Y, held);
    end
  endtask

  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;
    held   = 32'h0;

    table_v[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    table_v[1] = '{32'hFFFF_0000, 32'hFC60_039F};
    table_v[2] = '{32'hF0F0_F0F0, 32'hA5A5_A5A5};
    table_v[3] = '{32'hCCCC_CCCC, 32'hCCCC_CCCC};
    table_v[4] = '{32'hAAAA_AAAA, 32'hAAAA_AAAA};
    table_v[5] = '{32'h0000_0000, 32'h0000_0000};

    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 32'hDEAD_BEEF;
    #1;
    check("reset_Y", bus.Y, 32'h0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_ignores_inputs_Y", bus.Y, 32'h0);
    check("reset_ignores_inputs_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // Six directed words back-to-back, then one idle cycle.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, table_v[i].a, table_v[i].y, $sformatf("table%0d", i));
    end
    step(1'b0, 32'h1234_5678, 32'h0, "idle");

    // Asynchronous reset between edges discards a held result.
    step(1'b1, 32'hF0F0_F0F0, 32'hA5A5_A5A5, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_Y", bus.Y, 32'h0);
    check("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1;
    bus.A        = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("in_reset_Y", bus.Y, 32'h0);
    check("in_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    exp_q.delete();
    held = 32'h0;
    step(1'b1, 32'hFFFF_0000, 32'hFC60_039F, "post_reset");

    // Random sweep: mostly valid, occasional idle cycles.
    for (int i = 0; i < 1200; i++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) step(1'b0, r, 32'h0, "rand_idle");
      else                           step(1'b1, r, sigma1_ref(r), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_sigma1.md
MOD_SIGMA1 -- requirements
Module: mod_sigma1

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  A carries a word to transform this cycle.
REQ-005 A  input  32  input word, declared [0:31]; bit 0 is the MSB, bit 31 the LSB.
REQ-006 Y  output  32  registered result, declared [0:31]; bit 0 is the MSB.
REQ-007 out_valid  output  1  Y holds a result produced from an accepted A.

Function
REQ-008 The block SHALL compute the SHA-256 upper-case Sigma1: Y = ROTR6(A) XOR ROTR11(A) XOR ROTR25(A).
REQ-009 ROTRn SHALL be a 32-bit circular right rotation toward the LSB. Bits leaving the LSB re-enter at the MSB. No bits are shifted out or zero-filled.
REQ-010 In MSB-first indexing, Y[i] SHALL equal A[(i-6) mod 32] XOR A[(i-11) mod 32] XOR A[(i-25) mod 32].
REQ-011 Latency SHALL be exactly one clock. On a rising edge with in_valid=1, Y takes Sigma1(A) and out_valid takes 1.
REQ-012 On a rising edge with in_valid=0, out_valid SHALL become 0 and Y SHALL hold its previous value.
REQ-013 The block SHALL accept one word per cycle, back-to-back, with no stall or backpressure. Consecutive valid inputs produce consecutive valid outputs in order.
REQ-014 The datapath SHALL be purely bitwise. It SHALL have no carries, no arithmetic, and no data-dependent timing.
REQ-015 Y SHALL change only on a clock edge or reset. Changes on A between edges SHALL NOT propagate to Y.

Reset
REQ-016 When rst_n=0, Y SHALL go to 0x00000000 and out_valid to 0 immediately, without waiting for clk.
REQ-017 While rst_n=0, the block SHALL ignore in_valid and A.
REQ-018 After rst_n rises, the first rising edge SHALL operate normally per REQ-011/REQ-012.
REQ-019 If reset is asserted while a result is pending or held, that result SHALL be discarded. out_valid SHALL stay 0 until a new valid input is accepted.

Verification
REQ-020 A=0xFFFFFFFF, in_valid=1 -> one edge later Y=0xFFFFFFFF, out_valid=1.
REQ-021 A=0xFFFF0000 -> Y=0xFC60039F. A=0xF0F0F0F0 -> Y=0xA5A5A5A5. Each appears one edge after acceptance.
REQ-022 A=0xCCCCCCCC -> Y=0xCCCCCCCC. A=0xAAAAAAAA -> Y=0xAAAAAAAA. A=0x00000000 -> Y=0x00000000.
REQ-023 The bench SHALL drive those six words back-to-back with in_valid=1. It SHALL check that out_valid stays 1 and the results appear in order, each one cycle after its input.
REQ-024 The bench SHALL drive in_valid=0 for one cycle and check out_valid=0 with Y unchanged.
REQ-025 The bench SHALL assert rst_n=0 between clock edges and check that Y=0 and out_valid=0 immediately. It SHALL then release rst_n and check the next accepted 0xFFFF0000 yields 0xFC60039F.
REQ-026 The bench SHALL compare random A values each cycle against a reference model of REQ-008 (at least 1000 vectors).
